regfile_scan_ctrl: RTL and testbench
====================================

// Module: regfile_scan_ctrl
// PURPOSE
//  Debug/boot sequencer that drives the register file's read and write ports. DUMP streams x0..x31 out over a valid/ready port;
//  LOAD fills x1..x31 from a valid/ready input stream. cpu_hold stalls the core for the whole operation, so this block owns the
//  register-file ports while busy. Sits between the debug/boot interface and the register-file port mux.
// PARAMETERS
//  NREG   32  number of architectural registers (power of 2)
//  AW     5   register index width, $clog2(NREG)
//  DW     32  register data width
// PORTS
//  CLK        in   1   system clock, rising edge
//  RST        in   1   asynchronous reset, active-high
//  start      in   1   start request; sampled only in IDLE
//  mode       in   1   0 = DUMP, 1 = LOAD; sampled with start
//  busy       out  1   high from the cycle after start is accepted until DONE is left
//  done       out  1   one-cycle pulse when the operation completes
//  cpu_hold   out  1   equals busy; core must not touch the register file while high
//  readReg    out  AW  register-file read index
//  readData   in   DW  register-file read data; combinational from readReg; x0 reads 0
//  writeReg   out  AW  register-file write index
//  writeData  out  DW  register-file write data
//  RegWrite   out  1   register-file write enable; the register file writes on the CLK rise
//  dout_data  out  DW  dump stream data
//  dout_valid out  1   dump stream valid
//  dout_ready in   1   dump stream ready
//  din_data   in   DW  load stream data
//  din_valid  in   1   load stream valid
//  din_ready  out  1   load stream ready
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, idx=0, all outputs 0, dout_data=0.
//  FSM states: IDLE, DUMP, LOAD, DONE.
//   IDLE: start=1 at an edge -> DUMP (idx<=0) if mode=0; LOAD (idx<=1) if mode=1.
//   DUMP: readReg=idx.
//    - Capture condition: dout_valid=0 or (dout_valid & dout_ready) at an edge, and idx not yet past NREG-1.
//    - On capture: dout_data<=readData, dout_valid<=1, idx<=idx+1.
//    - First word is valid 1 cycle after DUMP is entered. Throughput is 1 word/cycle with ready held high.
//    - While dout_valid=1 & dout_ready=0, dout_data and dout_valid hold stable.
//    - After word NREG-1 is accepted (valid & ready, nothing left to capture): dout_valid<=0, -> DONE.
//   LOAD: din_ready=1; writeReg=idx; writeData=din_data; RegWrite=din_valid & din_ready (combinational).
//    - Each handshake writes x[idx] at that edge; idx<=idx+1.
//    - Write at idx=NREG-1 -> DONE, din_ready=0 from the next cycle.
//    - x0 is never written; LOAD consumes exactly NREG-1 words.
//   DONE: done=1 and busy=1 for one cycle -> IDLE.
//  busy=cpu_hold = (state != IDLE). start is ignored outside IDLE; mode changes while busy are ignored.
//  idx is AW+1 bits internally so the end-of-scan compare does not wrap; readReg/writeReg use idx[AW-1:0].
//  RegWrite is never asserted outside LOAD. readReg=0 and writeReg=0 in IDLE/DONE.
//  Reset mid-operation: FSM aborts to IDLE, no done pulse, stream outputs drop the same instant.
//   Registers already loaded keep their values; no rollback.
//  Stalls of any length on either stream are legal; there is no timeout.
// STRUCTURE
//  Package micro_pkg: typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_LOAD, ST_DONE} scan_state_t;
//   constants NREG, AW, DW, MODE_DUMP=1'b0, MODE_LOAD=1'b1.
//  Single always_ff for state/idx/dout regs plus one always_comb for port drive. No sub-module: the counter stays inline.
// TESTING (bench instantiates banco_registros + this block)
//  1 Reset: RST=1 mid-DUMP at word 10 -> all outputs 0 at once; busy=0; no done pulse; IDLE after release.
//  2 LOAD: start,mode=1; feed 31 words 32'h1000_0000+i, valid held high
//    -> 31 RegWrite pulses, writeReg 1..31, then done pulse; readReg k returns 32'h1000_0000+k-1.
//  3 x0: LOAD as in 2, then DUMP -> first word 32'h0, words 1..31 match the loaded data, 32 words total, then done.
//  4 Backpressure: DUMP with dout_ready low for 5 cycles on word 7 -> dout_data stays x7's value, no skip or duplicate.
//  5 Throughput: DUMP, ready always 1 -> dout_valid high 32 consecutive cycles; done exactly 1 cycle after the last accept.
//  6 start spam: pulse start mode=1 while a DUMP is busy -> ignored, RegWrite stays 0, dump completes normally.

Source files
------------

// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared types and constants for the register-file scan sequencer.
// Holds the FSM state encoding, register-file geometry and mode codes.
package micro_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  // Scan index is one bit wider than a register index so the end compare never wraps
  localparam logic [AW:0] IDX_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] IDX_END  = (AW+1)'(NREG);
  localparam logic [AW:0] IDX_LAST = (AW+1)'(NREG - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_LOAD,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Debug/boot sequencer owning the register-file ports while busy.
// DUMP streams x0..x31 out over valid/ready; LOAD fills x1..x31 from an input stream.
module regfile_scan_ctrl
  import micro_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic [AW-1:0] readReg,
  input  logic [DW-1:0] readData,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  output logic          RegWrite,
  output logic [DW-1:0] dout_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  input  logic [DW-1:0] din_data,
  input  logic          din_valid,
  output logic          din_ready
);

  scan_state_t   stateR, stateNextS;
  logic [AW:0]   idxR, idxNextS;
  logic [DW-1:0] doutDataR, doutDataNextS;
  logic          doutValidR, doutValidNextS;
  logic          captureS;

  // State, scan index and dump output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateR     <= ST_IDLE;
      idxR       <= IDX_ZERO;
      doutDataR  <= {DW{1'b0}};
      doutValidR <= 1'b0;
    end else begin
      stateR     <= stateNextS;
      idxR       <= idxNextS;
      doutDataR  <= doutDataNextS;
      doutValidR <= doutValidNextS;
    end
  end

  // Next-state logic: a dump word is captured whenever the output slot is empty or draining
  always_comb begin
    stateNextS     = stateR;
    idxNextS       = idxR;
    doutDataNextS  = doutDataR;
    doutValidNextS = doutValidR;
    captureS       = 1'b0;
    case (stateR)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_LOAD) begin
            stateNextS = ST_LOAD;
            idxNextS   = IDX_ONE;
          end else begin
            stateNextS = ST_DUMP;
            idxNextS   = IDX_ZERO;
          end
        end else begin
          idxNextS = IDX_ZERO;
        end
      end
      ST_DUMP: begin
        captureS = (!doutValidR || dout_ready) && (idxR < IDX_END);
        if (captureS) begin
          doutDataNextS  = readData;
          doutValidNextS = 1'b1;
          idxNextS       = idxR + IDX_ONE;
        end else if (doutValidR && dout_ready) begin
          doutValidNextS = 1'b0;
          stateNextS     = ST_DONE;
        end else begin
          doutValidNextS = doutValidR;
        end
      end
      ST_LOAD: begin
        if (din_valid) begin
          idxNextS = idxR + IDX_ONE;
          if (idxR == IDX_LAST) begin
            stateNextS = ST_DONE;
          end else begin
            stateNextS = ST_LOAD;
          end
        end else begin
          idxNextS = idxR;
        end
      end
      ST_DONE: begin
        stateNextS = ST_IDLE;
        idxNextS   = IDX_ZERO;
      end
      default: begin
        stateNextS     = ST_IDLE;
        idxNextS       = IDX_ZERO;
        doutValidNextS = 1'b0;
      end
    endcase
  end

  // Port drive; register-file ports are parked at index 0 unless the matching scan is active
  always_comb begin
    busy       = (stateR != ST_IDLE);
    cpu_hold   = (stateR != ST_IDLE);
    done       = (stateR == ST_DONE);
    dout_data  = doutDataR;
    dout_valid = doutValidR;
    readReg    = {AW{1'b0}};
    writeReg   = {AW{1'b0}};
    writeData  = {DW{1'b0}};
    RegWrite   = 1'b0;
    din_ready  = 1'b0;
    if (stateR == ST_DUMP) begin
      readReg = idxR[AW-1:0];
    end else begin
      readReg = {AW{1'b0}};
    end
    if (stateR == ST_LOAD) begin
      writeReg  = idxR[AW-1:0];
      writeData = din_data;
      din_ready = 1'b1;
      RegWrite  = din_valid;
    end else begin
      writeReg  = {AW{1'b0}};
      writeData = {DW{1'b0}};
      din_ready = 1'b0;
      RegWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Directed bench for regfile_scan_ctrl with a behavioural register file alongside.
module tb_regfile_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done, cpu_hold;
  logic [4:0]  readReg, writeReg;
  logic [31:0] readData, writeData;
  logic        RegWrite;
  logic [31:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] din_data = 32'h0;
  logic        din_valid = 1'b0;
  logic        din_ready;

  logic [31:0] rf   [32];
  logic [31:0] gold [32];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_scan_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode),
    .busy(busy), .done(done), .cpu_hold(cpu_hold),
    .readReg(readReg), .readData(readData),
    .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready)
  );

  // Register file model: combinational read, x0 hardwired to zero
  assign readData = (readReg == 5'd0) ? 32'h0 : rf[readReg];
  always @(posedge CLK) begin
    if (RegWrite && writeReg != 5'd0) rf[writeReg] <= writeData;
  end

  task automatic test_reset();
    int w;
    int cyc;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, done, cpu_hold, dout_valid, RegWrite, din_ready} !== 6'b0 ||
        dout_data !== 32'h0 || readReg !== 5'd0 || writeReg !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b data=%h rr=%0d wr=%0d, required all 0",
               busy, done, dout_valid, dout_data, readReg, writeReg);
    end
    RST = 1'b0;
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; dout_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    w = 0; cyc = 0;
    while (cyc < 100) begin
      if (dout_valid) begin
        checks++;
        if (dout_data !== gold[w]) begin
          errors++;
          $display("FAIL reset_pre_word%0d: got %h, required %h", w, dout_data, gold[w]);
        end
        if (w == 10) break;
        w++;
      end
      cyc++;
      @(negedge CLK);
    end
    checks++;
    if (w != 10) begin
      errors++;
      $display("FAIL reset_timeout: reached word %0d, required 10", w);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({busy, done, cpu_hold, dout_valid} !== 4'b0 || dout_data !== 32'h0 || readReg !== 5'd0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b valid=%b data=%h rr=%0d, required all 0",
               busy, done, dout_valid, dout_data, readReg);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_after: busy=%b done=%b valid=%b, required 0 0 0", busy, done, dout_valid);
      end
    end
  endtask

  task automatic test_load();
    int pulses;
    pulses = 0;
    @(negedge CLK);
    start = 1'b1; mode = 1'b1; din_valid = 1'b1;
    @(negedge CLK);
    start = 1'b0; mode = 1'b0;
    for (int i = 0; i < 31; i++) begin
      din_data = 32'h1000_0000 + i;
      gold[i+1] = 32'h1000_0000 + i;
      #1;
      if (RegWrite === 1'b1) pulses++;
      checks++;
      if (writeReg !== 5'(i + 1) || writeData !== din_data || din_ready !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL load_word%0d: wr=%0d wd=%h rdy=%b busy=%b, required wr=%0d wd=%h rdy=1 busy=1",
                 i, writeReg, writeData, din_ready, busy, i + 1, din_data);
      end
      @(negedge CLK);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || din_ready !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%b busy=%b rdy=%b we=%b, required 1 1 0 0", done, busy, din_ready, RegWrite);
    end
    din_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    checks++;
    if (pulses != 31) begin
      errors++;
      $display("FAIL load_pulses: got %0d, required 31", pulses);
    end
    for (int k = 1; k < 32; k++) begin
      checks++;
      if (rf[k] !== 32'h1000_0000 + k - 1) begin
        errors++;
        $display("FAIL load_readback x%0d: got %h, required %h", k, rf[k], 32'h1000_0000 + k - 1);
      end
    end
  endtask

  task automatic run_dump(input string name, input int stallWord, input int stallLen, input bit spam);
    int w;
    int stallCnt;
    int validCycles;
    int cyc;
    w = 0; stallCnt = 0; validCycles = 0; cyc = 0;
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; dout_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_entry: valid=%b busy=%b hold=%b, required 0 1 1", name, dout_valid, busy, cpu_hold);
    end
    while (w < 32 && cyc < 200) begin
      start = spam && (w < 28);
      mode  = start;
      if (w == stallWord && stallCnt < stallLen) begin
        dout_ready = 1'b0;
        stallCnt++;
      end else begin
        dout_ready = 1'b1;
      end
      checks++;
      if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL %s_regwrite: got %b, required 0", name, RegWrite);
      end
      if (dout_valid) begin
        validCycles++;
        checks++;
        if (dout_data !== gold[w]) begin
          errors++;
          $display("FAIL %s_word%0d: got %h, required %h", name, w, dout_data, gold[w]);
        end
        if (dout_ready) w++;
      end
      cyc++;
      @(negedge CLK);
    end
    start = 1'b0; mode = 1'b0;
    checks++;
    if (w != 32) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0d words, required 32", name, w);
    end
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b, required 1 0 1", name, done, dout_valid, busy);
    end
    checks++;
    if (validCycles != 32 + stallLen) begin
      errors++;
      $display("FAIL %s_valid_cycles: got %0d, required %0d", name, validCycles, 32 + stallLen);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b rdy=%b, required 0 0 0", name, done, busy, din_ready);
    end
  endtask

  task automatic test_x0_dump();
    run_dump("x0dump", -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_dump("backpressure", 7, 5, 1'b0);
  endtask

  task automatic test_throughput();
    run_dump("throughput", -1, 0, 1'b0);
  endtask

  task automatic test_start_spam();
    run_dump("startspam", -1, 0, 1'b1);
  endtask

  initial begin
    rf[0] = 32'h0;
    gold[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      rf[i]   = 32'hC0DE_0000 + i;
      gold[i] = 32'hC0DE_0000 + i;
    end
    test_reset();
    test_load();
    test_x0_dump();
    test_backpressure();
    test_throughput();
    test_start_spam();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
